// File: rtl/multicycle_alu_control.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute,
// time-shares the ALU, and issues memory and register-file enables.
module multicycle_alu_control #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            Beq_alu,
  input  logic            mem_ready,
  output logic [3:0]      ALU_selection,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IorD,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic [3:0]      state,
  output logic            illegal,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ALU_WB   = 4'd4,  S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
    S_MEM_WR   = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_HALT   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    C_R = 3'd0, C_I = 3'd1, C_MEM = 3'd2, C_BR = 3'd3, C_JMP = 3'd4, C_HALT = 3'd5, C_ILL = 3'd6
  } class_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_BEQ  = 6'b100010;
  localparam logic [5:0] OP_BNE  = 6'b100011;
  localparam logic [5:0] OP_JMP  = 6'b100100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // True for the ALU operation codes the datapath implements.
  function automatic logic alu_code_ok(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0111, 4'b1001: alu_code_ok = 1'b1;
      default:                            alu_code_ok = 1'b0;
    endcase
  endfunction

  // Maps an opcode to its instruction class; bad ALU codes are illegal.
  function automatic class_t classify(input logic [5:0] op);
    case (op[5:4])
      2'b00:   classify = alu_code_ok(op[3:0]) ? C_R : C_ILL;
      2'b01:   classify = alu_code_ok(op[3:0]) ? C_I : C_ILL;
      default: begin
        case (op)
          OP_LW, OP_SW:   classify = C_MEM;
          OP_BEQ, OP_BNE: classify = C_BR;
          OP_JMP:         classify = C_JMP;
          OP_HALT:        classify = C_HALT;
          default:        classify = C_ILL;
        endcase
      end
    endcase
  endfunction

  state_t            state_q;
  logic [5:0]        opcode_q;
  logic              illegal_q;
  logic [CNTW-1:0]   count_q;
  logic [CNTW-1:0]   count_d;
  logic              retire_s;
  logic              pc_write_s;
  logic              ir_write_s;
  logic              mem_write_s;
  logic              reg_write_s;

  // Retirement happens on the last edge of every legal, non-halting instruction.
  always_comb begin
    retire_s = 1'b0;
    case (state_q)
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire_s = 1'b1;
      S_MEM_WR:                             retire_s = mem_ready;
      default:                              retire_s = 1'b0;
    endcase
    if (retire_s) begin
      count_d = count_q + CNTW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Control FSM: state sequencing, opcode latch, sticky illegal flag, retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= 6'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      count_q <= count_d;
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= opcode[5:0];
          case (classify(opcode[5:0]))
            C_R:     state_q <= S_EXEC_R;
            C_I:     state_q <= S_EXEC_I;
            C_MEM:   state_q <= S_MEM_ADDR;
            C_BR:    state_q <= S_BRANCH;
            C_JMP:   state_q <= S_JUMP;
            C_HALT:  state_q <= S_HALT;
            default: begin
              state_q   <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I:                   state_q <= S_ALU_WB;
        S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_q <= S_FETCH;
        S_MEM_ADDR: state_q <= (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_HALT:     state_q <= S_HALT;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; write enables are additionally gated by reset.
  always_comb begin
    ALU_selection = ALU_ADD;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    MemRead       = 1'b0;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    pc_write_s    = 1'b0;
    ir_write_s    = 1'b0;
    mem_write_s   = 1'b0;
    reg_write_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE:   ALUSrcB = 2'b10;
      S_EXEC_R: begin
        ALUSrcA       = 1'b1;
        ALU_selection = opcode_q[3:0];
        RegDst        = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_selection = opcode_q[3:0];
      end
      S_ALU_WB: begin
        reg_write_s = 1'b1;
        RegDst      = ~opcode_q[4];
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        MemtoReg    = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        IorD        = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALU_selection = ALU_SUB;
        PCSource      = 2'b01;
        pc_write_s    = (opcode_q == OP_BEQ) ? Beq_alu : ~Beq_alu;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
        ALU_selection = ALU_ADD;
      end
    endcase
    PCWrite  = pc_write_s & rst_n;
    IRWrite  = ir_write_s & rst_n;
    MemWrite = mem_write_s & rst_n;
    RegWrite = reg_write_s & rst_n;
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign halted      = (state_q == S_HALT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_alu_control.sv
// Bench for multicycle_alu_control: directed plan plus random instruction
// stream checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_alu_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        Beq_alu;
  logic        mem_ready;
  logic [3:0]  ALU_selection;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg;
  logic [3:0]  state;
  logic        illegal, halted;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit exp_illegal = 1'b0;

  localparam int FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, ALU_WB = 4, MEM_ADDR = 5,
                 MEM_RD = 6, MEM_WB = 7, MEM_WR = 8, BRANCH = 9, JUMP = 10, HALT = 11;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                 K_JMP = 6, K_HALT = 7, K_ILL = 8;

  multicycle_alu_control #(.OPW(6), .CNTW(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .Beq_alu(Beq_alu), .mem_ready(mem_ready),
    .ALU_selection(ALU_selection), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .state(state),
    .illegal(illegal), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {ALU_selection, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite, MemRead,
                     MemWrite, IorD, RegWrite, RegDst, MemtoReg, halted};

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic int op_kind(input logic [5:0] op);
    int ok_codes[8] = '{0, 1, 2, 3, 4, 5, 7, 9};
    if (op[5] == 1'b0) begin
      foreach (ok_codes[i]) if (int'(op[3:0]) == ok_codes[i]) return (op[4] ? K_I : K_R);
      return K_ILL;
    end
    if (op == 6'd32) return K_LW;
    if (op == 6'd33) return K_SW;
    if (op == 6'd34) return K_BEQ;
    if (op == 6'd35) return K_BNE;
    if (op == 6'd36) return K_JMP;
    if (op == 6'd63) return K_HALT;
    return K_ILL;
  endfunction

  // Expected control word for a state of the instruction op.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op, input bit mr, input bit beq);
    logic [3:0] alu = 4'b0010;
    logic sa = 1'b0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic pcw = 1'b0, irw = 1'b0, mrd = 1'b0, mw = 1'b0, iord = 1'b0;
    logic rw = 1'b0, rd = 1'b0, m2r = 1'b0, h = 1'b0;
    case (st)
      FETCH:    begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
      DECODE:   sb = 2'b10;
      EXEC_R:   begin sa = 1'b1; alu = op[3:0]; rd = 1'b1; end
      EXEC_I:   begin sa = 1'b1; sb = 2'b10; alu = op[3:0]; end
      ALU_WB:   begin rw = 1'b1; rd = (op_kind(op) == K_R); end
      MEM_ADDR: begin sa = 1'b1; sb = 2'b10; end
      MEM_RD:   begin mrd = 1'b1; iord = 1'b1; end
      MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
      MEM_WR:   begin mw = 1'b1; iord = 1'b1; end
      BRANCH:   begin sa = 1'b1; alu = 4'b0011; ps = 2'b01;
                      pcw = (op_kind(op) == K_BEQ) ? beq : ~beq; end
      JUMP:     begin ps = 2'b10; pcw = 1'b1; end
      HALT:     h = 1'b1;
      default:  ;
    endcase
    return {alu, sa, sb, ps, pcw, irw, mrd, mw, iord, rw, rd, m2r, h};
  endfunction

  // One clock: drive at the falling edge, check shortly after.
  task automatic step(input int st, input bit mr, input logic [5:0] drive_op,
                      input logic [5:0] inst_op, input bit beq);
    @(negedge clk);
    mem_ready = mr;
    opcode    = drive_op;
    Beq_alu   = beq;
    #1;
    check($sformatf("state(exp %0d op %0h)", st, inst_op), 64'(state), 64'(st));
    check($sformatf("ctrl(st %0d op %0h mr %0d)", st, inst_op, mr), 64'(dut_ctrl),
          64'(exp_ctrl(st, inst_op, mr, beq)));
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Runs one whole instruction; fw/rw are memory wait cycles in fetch and MEM_RD/MEM_WR.
  task automatic run_instr(input logic [5:0] op, input int fw, input int rw, input bit beq);
    int k;
    k = op_kind(op);
    for (int i = 0; i < fw; i++) step(FETCH, 1'b0, 6'($urandom), op, rb());
    step(FETCH, 1'b1, 6'($urandom), op, rb());
    check("instr_count", 64'(instr_count), 64'(exp_count));
    check("illegal", 64'(illegal), 64'(exp_illegal));
    step(DECODE, rb(), op, op, rb());
    case (k)
      K_R, K_I: begin
        step((k == K_R) ? EXEC_R : EXEC_I, rb(), 6'($urandom), op, rb());
        step(ALU_WB, rb(), 6'($urandom), op, rb());
      end
      K_LW: begin
        step(MEM_ADDR, rb(), 6'($urandom), op, rb());
        for (int i = 0; i < rw; i++) step(MEM_RD, 1'b0, 6'($urandom), op, rb());
        step(MEM_RD, 1'b1, 6'($urandom), op, rb());
        step(MEM_WB, rb(), 6'($urandom), op, rb());
      end
      K_SW: begin
        step(MEM_ADDR, rb(), 6'($urandom), op, rb());
        for (int i = 0; i < rw; i++) step(MEM_WR, 1'b0, 6'($urandom), op, rb());
        step(MEM_WR, 1'b1, 6'($urandom), op, rb());
      end
      K_BEQ, K_BNE: step(BRANCH, rb(), 6'($urandom), op, beq);
      K_JMP:        step(JUMP, rb(), 6'($urandom), op, rb());
      default:      ;
    endcase
    if (k == K_ILL) exp_illegal = 1'b1;
    else            exp_count++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_state", 64'(state), 64'(FETCH));
    check("rst_wen", 64'({PCWrite, IRWrite, MemWrite, RegWrite}), 64'(0));
    check("rst_flags", 64'({illegal, halted}), 64'(0));
    check("rst_count", 64'(instr_count), 64'(0));
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    exp_illegal = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] legal_ops[6] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd0};
    int ok_alu[8] = '{0, 1, 2, 3, 4, 5, 7, 9};
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; Beq_alu = 1'b0;
    do_reset();

    // Directed plan
    run_instr(6'b000010, 0, 0, 1'b0);
    run_instr(6'b100000, 0, 2, 1'b0);
    run_instr(6'b100010, 0, 0, 1'b1);
    run_instr(6'b100011, 0, 0, 1'b1);
    run_instr(6'b000110, 0, 0, 1'b0);
    run_instr(6'b010111, 1, 0, 1'b0);
    run_instr(6'b100001, 2, 3, 1'b0);
    run_instr(6'b100100, 0, 0, 1'b0);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0: op = 6'($urandom_range(0, 62));
        1: op = {1'b0, 1'($urandom), 4'(ok_alu[$urandom_range(0, 7)])};
        default: op = legal_ops[$urandom_range(0, 4)];
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end
    step(FETCH, 1'b0, 6'd0, 6'd0, 1'b0);
    check("count_after_random", 64'(instr_count), 64'(exp_count));
    check("illegal_after_random", 64'(illegal), 64'(exp_illegal));

    // Reset during a stalled store
    do_reset();
    step(FETCH, 1'b1, 6'd0, 6'd0, 1'b0);
    step(DECODE, 1'b0, 6'b100001, 6'b100001, 1'b0);
    step(MEM_ADDR, 1'b0, 6'd0, 6'b100001, 1'b0);
    step(MEM_WR, 1'b0, 6'd0, 6'b100001, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("memwrite_before_rst", 64'(MemWrite), 64'(1));
    rst_n = 1'b0;
    #1;
    check("memwrite_in_rst", 64'(MemWrite), 64'(0));
    check("state_in_rst", 64'(state), 64'(FETCH));
    check("count_in_rst", 64'(instr_count), 64'(0));
    mem_ready = 1'b1;
    #1;
    check("fetch_wen_in_rst", 64'({PCWrite, IRWrite}), 64'(0));
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;

    // HALT holds for 20 cycles, reset resumes fetching
    run_instr(6'b000101, 0, 0, 1'b0);
    step(FETCH, 1'b1, 6'd0, 6'd63, 1'b0);
    step(DECODE, 1'b1, 6'd63, 6'd63, 1'b0);
    for (int i = 0; i < 20; i++) step(HALT, rb(), 6'($urandom), 6'd63, rb());
    check("count_in_halt", 64'(instr_count), 64'(exp_count));
    do_reset();
    run_instr(6'b010100, 0, 0, 1'b0);
    step(FETCH, 1'b0, 6'd0, 6'd0, 1'b0);
    check("count_after_halt_reset", 64'(instr_count), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
